conf_rst_sequencer: RTL and testbench

CONF_RST_SEQUENCER -- requirements
Module: conf_rst_sequencer

---
 rtl/conf_rst_pkg.sv | 22 ++
 rtl/conf_rst_wdt.sv | 31 +++
 rtl/conf_rst_sequencer.sv | 131 +++++++++++++
 tb/tb_conf_rst_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/conf_rst_pkg.sv
// Shared types and constants for the reset sequencer: FSM state encoding,
// output polarity names and the counter width helper.
package conf_rst_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_e;

  localparam string POL_ACTIVE_HIGH = "ACTIVE_HIGH";
  localparam string POL_ACTIVE_LOW  = "ACTIVE_LOW";

  // Bits needed to hold the larger of two terminal counts without wrapping.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    if (m < 1) m = 1;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/conf_rst_wdt.sv
// Run-time watchdog for the reset sequencer; counts only while the sequencer is
// in RUN and flags expiry combinationally so the restart lands on the same edge.
module conf_rst_wdt
  import conf_rst_pkg::*;
#(
  parameter int WDT_TIMEOUT = 1024
) (
  input  logic clk_i,
  input  logic clr_i,
  input  logic run_i,
  input  logic kick_i,
  output logic expire_o
);

  localparam int WDT_W = cnt_width(WDT_TIMEOUT - 1, 1);
  localparam logic [WDT_W-1:0] LAST_CNT = WDT_W'(WDT_TIMEOUT - 1);

  logic [WDT_W-1:0] cnt;

  // A kick in the final cycle suppresses expiry.
  assign expire_o = run_i && !kick_i && (cnt == LAST_CNT);

  always_ff @(posedge clk_i) begin
    if (clr_i || !run_i || kick_i) begin
      cnt <= '0;
    end else if (cnt != LAST_CNT) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/conf_rst_sequencer.sv
// Sequenced reset generator: holds all outputs asserted, then releases bit 0..N-1
// at fixed step intervals. Define CONF_RST_SEQ_WDT_EN to add the run-time watchdog.
module conf_rst_sequencer
  import conf_rst_pkg::*;
#(
  parameter int    NUM_OUT     = 4,
  parameter string OUT_RES_POL = "ACTIVE_HIGH",
  parameter int    HOLD_CYCLES = 16,
  parameter int    STEP_CYCLES = 4,
  parameter int    WDT_TIMEOUT = 1024
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               sw_rst_req_i,
`ifdef CONF_RST_SEQ_WDT_EN
  input  logic               wdt_kick_i,
  output logic               wdt_trip_o,
`endif
  output logic [NUM_OUT-1:0] rst_o,
  output logic               busy_o,
  output logic               done_o
);

  localparam int   CNT_W      = cnt_width(HOLD_CYCLES, STEP_CYCLES);
  localparam int   IDX_W      = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
  localparam logic ASSERT_LVL = (OUT_RES_POL == POL_ACTIVE_LOW) ? 1'b0 : 1'b1;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_OUT - 1);

  state_e             state;
  logic [CNT_W-1:0]   hold_cnt;
  logic [CNT_W-1:0]   step_cnt;
  logic [IDX_W-1:0]   idx;
  logic [NUM_OUT-1:0] rst_q;
  logic               busy_q;
  logic               done_q;
  logic               wdt_expire;
  logic               restart;

  assign restart = rst_i | sw_rst_req_i | wdt_expire;

`ifdef CONF_RST_SEQ_WDT_EN
  logic trip_q;

  conf_rst_wdt #(
    .WDT_TIMEOUT(WDT_TIMEOUT)
  ) u_wdt (
    .clk_i   (clk_i),
    .clr_i   (restart),
    .run_i   (state == ST_RUN),
    .kick_i  (wdt_kick_i),
    .expire_o(wdt_expire)
  );

  // Sticky across software and watchdog restarts; only the hard reset clears it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      trip_q <= 1'b0;
    end else if (wdt_expire) begin
      trip_q <= 1'b1;
    end
  end

  assign wdt_trip_o = trip_q;
`else
  assign wdt_expire = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (restart) begin
      state    <= ST_ASSERT;
      hold_cnt <= '0;
      step_cnt <= '0;
      idx      <= '0;
      rst_q    <= {NUM_OUT{ASSERT_LVL}};
      busy_q   <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      case (state)
        ST_ASSERT: begin
          // hold_cnt equals the number of restart-free edges seen so far.
          if (hold_cnt == HOLD_LAST) begin
            rst_q[0] <= ~ASSERT_LVL;
            step_cnt <= '0;
            if (NUM_OUT == 1) begin
              state  <= ST_RUN;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else begin
              state <= ST_RELEASE;
              idx   <= IDX_W'(1);
            end
          end else if (hold_cnt != '1) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        ST_RELEASE: begin
          if (step_cnt == STEP_LAST) begin
            rst_q[idx] <= ~ASSERT_LVL;
            step_cnt   <= '0;
            if (idx == IDX_LAST) begin
              state  <= ST_RUN;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else begin
              idx <= idx + 1'b1;
            end
          end else if (step_cnt != '1) begin
            step_cnt <= step_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          state <= ST_RUN;
        end
        default: begin
          state  <= ST_ASSERT;
          rst_q  <= {NUM_OUT{ASSERT_LVL}};
          busy_q <= 1'b1;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign rst_o  = rst_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule

// File: tb/tb_conf_rst_sequencer.sv
// Bench for conf_rst_sequencer: an active-high and an active-low instance share
// stimulus and are compared each cycle against a release-time model.
module tb_conf_rst_sequencer;

  localparam int NO   = 4;
  localparam int HC   = 16;
  localparam int SC   = 4;
  localparam int TMO  = 8;
  localparam int LAST = HC + (NO - 1) * SC;

  logic          clk = 1'b0;
  logic          rst_i = 1'b0;
  logic          sw = 1'b0;
  logic [NO-1:0] rst_h, rst_l;
  logic          busy_h, done_h, busy_l, done_l;
`ifdef CONF_RST_SEQ_WDT_EN
  logic          kick = 1'b0;
  logic          trip_h, trip_l;
`endif

  // Model: edges since last restart, idle RUN cycles, sticky trip.
  int   n_m = 0;
  int   idle_m = 0;
  logic trip_m = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  conf_rst_sequencer #(
    .NUM_OUT(NO), .OUT_RES_POL("ACTIVE_HIGH"), .HOLD_CYCLES(HC),
    .STEP_CYCLES(SC), .WDT_TIMEOUT(TMO)
  ) dut_h (
    .clk_i(clk), .rst_i(rst_i), .sw_rst_req_i(sw),
`ifdef CONF_RST_SEQ_WDT_EN
    .wdt_kick_i(kick), .wdt_trip_o(trip_h),
`endif
    .rst_o(rst_h), .busy_o(busy_h), .done_o(done_h)
  );

  conf_rst_sequencer #(
    .NUM_OUT(NO), .OUT_RES_POL("ACTIVE_LOW"), .HOLD_CYCLES(HC),
    .STEP_CYCLES(SC), .WDT_TIMEOUT(TMO)
  ) dut_l (
    .clk_i(clk), .rst_i(rst_i), .sw_rst_req_i(sw),
`ifdef CONF_RST_SEQ_WDT_EN
    .wdt_kick_i(kick), .wdt_trip_o(trip_l),
`endif
    .rst_o(rst_l), .busy_o(busy_l), .done_o(done_l)
  );

  // Bit k is released once HC + k*SC restart-free edges have passed.
  function automatic logic [2*NO+3:0] exp_vec();
    logic [NO-1:0] h;
    logic          b;
    for (int k = 0; k < NO; k++) h[k] = (n_m < HC + k * SC);
    b = (n_m < LAST);
    return {h, ~h, b, ~b, b, ~b};
  endfunction

  function automatic logic [2*NO+3:0] obs_vec();
    return {rst_h, rst_l, busy_h, done_h, busy_l, done_l};
  endfunction

  // Advance one clock edge and update the model from the inputs seen at it.
  task automatic tick();
    logic wexp;
    wexp = 1'b0;
`ifdef CONF_RST_SEQ_WDT_EN
    if (n_m >= LAST) begin
      if (kick) idle_m = 0;
      else      idle_m++;
      if (idle_m >= TMO) wexp = 1'b1;
    end else begin
      idle_m = 0;
    end
`endif
    @(posedge clk);
    if (rst_i || sw || wexp) begin
      n_m    = 0;
      idle_m = 0;
    end else if (n_m < 100000) begin
      n_m++;
    end
    if (rst_i)     trip_m = 1'b0;
    else if (wexp) trip_m = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    sw    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++;
      if (obs_vec() !== exp_vec())
        $display("FAIL reset cyc=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
      else n_pass++;
`ifdef CONF_RST_SEQ_WDT_EN
      n_chk++;
      if ({trip_h, trip_l} !== 2'b00)
        $display("FAIL reset_trip got=%b exp=00", {trip_h, trip_l});
      else n_pass++;
`endif
    end
    rst_i = 1'b0;
  endtask

  task automatic test_sequence();
    for (int i = 1; i <= LAST + 6; i++) begin
      tick();
      n_chk++;
      if (obs_vec() !== exp_vec())
        $display("FAIL sequence edge=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
      else n_pass++;
    end
    n_chk++;
    if ({rst_h, rst_l} !== {4'b0000, 4'b1111})
      $display("FAIL sequence_final got=%b exp=00001111", {rst_h, rst_l});
    else n_pass++;
  endtask

  task automatic test_sw_pulse();
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    for (int i = 1; i <= 22 + LAST + 4; i++) begin
      sw = (i == 22);
      tick();
      n_chk++;
      if (obs_vec() !== exp_vec())
        $display("FAIL sw_pulse edge=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
      else n_pass++;
    end
    sw = 1'b0;
  endtask

  task automatic test_sw_hold();
    for (int i = 0; i < 10 + LAST + 4; i++) begin
      sw = (i < 10);
      tick();
      n_chk++;
      if (obs_vec() !== exp_vec())
        $display("FAIL sw_hold cyc=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
      else n_pass++;
    end
    sw = 1'b0;
  endtask

  task automatic test_random();
    int hold_sw;
    hold_sw = 0;
    for (int i = 0; i < 500; i++) begin
      if (hold_sw == 0 && $urandom_range(0, 39) == 0) hold_sw = $urandom_range(1, 12);
      sw = (hold_sw > 0);
      if (hold_sw > 0) hold_sw--;
      rst_i = ($urandom_range(0, 149) == 0);
`ifdef CONF_RST_SEQ_WDT_EN
      kick = ($urandom_range(0, 9) < 2);
`endif
      tick();
      n_chk++;
      if (obs_vec() !== exp_vec())
        $display("FAIL random cyc=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
      else n_pass++;
`ifdef CONF_RST_SEQ_WDT_EN
      n_chk++;
      if ({trip_h, trip_l} !== {trip_m, trip_m})
        $display("FAIL random_trip cyc=%0d got=%b exp=%b", i, {trip_h, trip_l}, {trip_m, trip_m});
      else n_pass++;
`endif
    end
    sw    = 1'b0;
    rst_i = 1'b0;
`ifdef CONF_RST_SEQ_WDT_EN
    kick  = 1'b0;
`endif
  endtask

`ifdef CONF_RST_SEQ_WDT_EN
  task automatic test_wdt_expire();
    rst_i = 1'b1; kick = 1'b0; tick(); rst_i = 1'b0;
    for (int i = 0; i < LAST + TMO + LAST + 10; i++) begin
      sw = (i == LAST + TMO + 20);
      tick();
      n_chk++;
      if ({obs_vec(), trip_h, trip_l} !== {exp_vec(), trip_m, trip_m})
        $display("FAIL wdt_expire cyc=%0d got=%b exp=%b", i,
                 {obs_vec(), trip_h, trip_l}, {exp_vec(), trip_m, trip_m});
      else n_pass++;
    end
    sw = 1'b0;
    n_chk++;
    if (trip_h !== 1'b1) $display("FAIL wdt_trip_sticky got=%b exp=1", trip_h);
    else n_pass++;
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    n_chk++;
    if ({trip_h, trip_l} !== 2'b00) $display("FAIL wdt_trip_clear got=%b exp=00", {trip_h, trip_l});
    else n_pass++;
  endtask

  task automatic test_wdt_kick();
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    for (int i = 0; i < LAST; i++) tick();
    // Kick every 7th RUN cycle, then once exactly in the would-be expiry cycle.
    for (int i = 0; i < 43; i++) begin
      kick = (i < 35) ? ((i % 7) == 6) : (i == 42);
      tick();
      n_chk++;
      if ({obs_vec(), trip_h, trip_l} !== {exp_vec(), trip_m, trip_m})
        $display("FAIL wdt_kick cyc=%0d got=%b exp=%b", i,
                 {obs_vec(), trip_h, trip_l}, {exp_vec(), trip_m, trip_m});
      else n_pass++;
    end
    kick = 1'b0;
    n_chk++;
    if ({done_h, trip_h} !== 2'b10) $display("FAIL wdt_kick_wins got=%b exp=10", {done_h, trip_h});
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_sequence();
    test_sw_pulse();
    test_sw_hold();
`ifdef CONF_RST_SEQ_WDT_EN
    test_wdt_expire();
    test_wdt_kick();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
